// File: rtl/lfa_adc_sampler_pkg.sv
// Shared types and defaults for the LFA sensor ADC sampler.
// Holds the FSM and channel enums plus the control-word helper.
package lfa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StLatch
    } state_e;

    typedef enum logic [1:0] {
        ChLeft,
        ChMiddle,
        ChRight
    } ch_e;

    localparam logic [2:0] DefChLeft   = 3'd3;
    localparam logic [2:0] DefChMiddle = 3'd4;
    localparam logic [2:0] DefChRight  = 3'd5;

    // SCLK edges per frame: 16 full periods.
    localparam int unsigned SckToggles = 32;

    function automatic ch_e next_ch(input ch_e ch);
        case (ch)
            ChLeft:   return ChMiddle;
            ChMiddle: return ChRight;
            default:  return ChLeft;
        endcase
    endfunction

    function automatic logic [15:0] ctrl_word(input logic [2:0] addr);
        return {2'b00, addr, 11'b0};
    endfunction

endpackage

// File: rtl/lfa_adc_sampler_if.sv
// ADC serial pins plus the sampled sensor outputs, seen from the sampler (master)
// and from the ADC/consumer side (slave).
interface lfa_adc_sampler_if;

    logic        adc_dout;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        adc_din;
    logic [11:0] left;
    logic [11:0] middle;
    logic [11:0] right;
    logic        data_valid;

    modport master (
        input  adc_dout,
        output adc_cs_n,
        output adc_sck,
        output adc_din,
        output left,
        output middle,
        output right,
        output data_valid
    );

    modport slave (
        output adc_dout,
        input  adc_cs_n,
        input  adc_sck,
        input  adc_din,
        input  left,
        input  middle,
        input  right,
        input  data_valid
    );

endinterface

// File: rtl/lfa_adc_sampler_sck_divider.sv
// SCLK generator: 32 toggles every CLK_DIV cycles while enabled, then one idle
// half-period before o_done. Idles high; strobes fire the cycle before the edge.
module sck_divider
    import lfa_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall,
    output logic o_done
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] r_div_cnt;
    logic [5:0]      r_tgl_cnt;
    logic            r_sck;
    logic            w_tick;
    logic            w_toggle;

    assign w_tick   = i_en && (r_div_cnt == CntMax);
    assign w_toggle = w_tick && (r_tgl_cnt < 6'(SckToggles));

    assign o_sck  = r_sck;
    assign o_fall = w_toggle && r_sck;
    assign o_rise = w_toggle && !r_sck;
    assign o_done = w_tick && !w_toggle;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_div_cnt <= '0;
            r_tgl_cnt <= '0;
            r_sck     <= 1'b1;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_toggle) begin
                r_sck     <= !r_sck;
                r_tgl_cnt <= r_tgl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfa_adc_sampler.sv
// Round-robin sampler for three line-follower sensors on an ADC128S022-type ADC.
// Each frame sends the next channel address and receives the previous one's data.
module lfa_adc_sampler
    import lfa_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned GAP_CYC   = 16,
    parameter logic [2:0]  CH_LEFT   = DefChLeft,
    parameter logic [2:0]  CH_MIDDLE = DefChMiddle,
    parameter logic [2:0]  CH_RIGHT  = DefChRight
) (
    input logic               clk_50M,
    input logic               rst,
    lfa_adc_sampler_if.master adc_bus
);

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(GAP_CYC - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [GapW-1:0] r_gap_cnt;
    logic [GapW-1:0] w_gap_nxt;
    logic            w_frame_start;
    logic            w_frame_end;

    logic            r_cs_n;
    logic [15:0]     r_din_sr;
    logic            r_fall_seen;
    logic [15:0]     r_shift;
    ch_e             r_ch;
    logic            r_first;
    logic [11:0]     r_left;
    logic [11:0]     r_middle;
    logic [11:0]     r_right;
    logic            r_valid;

    logic            w_sck;
    logic            w_rise;
    logic            w_fall;
    logic            w_done;
    logic [2:0]      w_addr;
    logic            w_unused_shift_hi;

    sck_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_divider (
        .i_clk (clk_50M),
        .i_rst (rst),
        .i_en  (r_state == StFrame),
        .o_sck (w_sck),
        .o_rise(w_rise),
        .o_fall(w_fall),
        .o_done(w_done)
    );

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state   <= StIdle;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap_cnt;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_gap_cnt == GapMax) begin
                    w_state_nxt   = StFrame;
                    w_gap_nxt     = '0;
                    w_frame_start = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            StFrame: begin
                if (w_done) begin
                    w_state_nxt = StLatch;
                    w_frame_end = 1'b1;
                end
            end
            StLatch: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_addr = CH_LEFT;
        unique case (r_ch)
            ChMiddle: w_addr = CH_MIDDLE;
            ChRight:  w_addr = CH_RIGHT;
            default:  w_addr = CH_LEFT;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_cs_n      <= 1'b1;
            r_din_sr    <= '0;
            r_fall_seen <= 1'b0;
            r_shift     <= '0;
            r_ch        <= ChLeft;
            r_first     <= 1'b1;
            r_left      <= '0;
            r_middle    <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Bit 15 is already on DIN at cs_n fall, so the first SCLK fall holds it.
            if (w_frame_start) begin
                r_cs_n      <= 1'b0;
                r_din_sr    <= ctrl_word(w_addr);
                r_fall_seen <= 1'b0;
            end else if (w_fall) begin
                if (r_fall_seen) begin
                    r_din_sr <= {r_din_sr[14:0], 1'b0};
                end
                r_fall_seen <= 1'b1;
            end
            if (w_rise) begin
                r_shift <= {r_shift[14:0], adc_bus.adc_dout};
            end
            if (w_frame_end) begin
                r_cs_n   <= 1'b1;
                r_din_sr <= '0;
                // Received data belongs to the address sent one frame earlier.
                if (!r_first) begin
                    unique case (r_ch)
                        ChMiddle: r_left   <= r_shift[11:0];
                        ChRight:  r_middle <= r_shift[11:0];
                        ChLeft: begin
                            r_right <= r_shift[11:0];
                            r_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (r_state == StLatch) begin
                r_ch    <= next_ch(r_ch);
                r_first <= 1'b0;
            end
        end
    end

    assign w_unused_shift_hi = ^r_shift[15:12];

    assign adc_bus.adc_cs_n   = r_cs_n;
    assign adc_bus.adc_sck    = w_sck;
    assign adc_bus.adc_din    = r_din_sr[15];
    assign adc_bus.left       = r_left;
    assign adc_bus.middle     = r_middle;
    assign adc_bus.right      = r_right;
    assign adc_bus.data_valid = r_valid;

endmodule

// File: tb/tb_lfa_adc_sampler.sv
// Scoreboard bench: an ADC model feeds per-frame data and predicts outputs from
// frame arithmetic; a monitor checks SCLK timing, DIN words and latched results.
module tb_lfa_adc_sampler;

    localparam int unsigned ClkDiv      = 8;
    localparam int unsigned GapCyc      = 16;
    localparam int          FramePeriod = GapCyc + 2 * ClkDiv * 16 + ClkDiv + 1;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] m;
        logic [11:0] r;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfa_adc_sampler_if bus ();

    lfa_adc_sampler #(
        .CLK_DIV  (ClkDiv),
        .GAP_CYC  (GapCyc),
        .CH_LEFT  (3'd3),
        .CH_MIDDLE(3'd4),
        .CH_RIGHT (3'd5)
    ) dut (
        .clk_50M(clk),
        .rst    (rst),
        .adc_bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [15:0] din_q[$];
    logic [11:0] fixed_val[3];
    bit          use_fixed;
    int          latch_cnt = 0;
    int          valid_cnt = 0;
    int          rise_cnt = 0;
    logic [15:0] last_din = '0;

    function automatic logic [2:0] addr_of(input int i);
        case (i)
            0:       return 3'd3;
            1:       return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ADC model and reference: frame k returns data of channel (k-2)%3.
    int          k;
    int          c;
    int          fall_idx;
    logic [11:0] mdl[3];
    logic [11:0] data;
    logic [15:0] tx_word;
    logic        m_prev_cs;
    logic        m_prev_sck;

    always @(negedge clk) begin
        if (rst) begin
            k = 0;
            for (int i = 0; i < 3; i++) mdl[i] = '0;
            sb_q.delete();
            din_q.delete();
            fall_idx = 16;
            m_prev_cs = 1'b1;
            m_prev_sck = 1'b1;
            bus.adc_dout = 1'b0;
        end else begin
            if (m_prev_cs && !bus.adc_cs_n) begin
                k++;
                din_q.push_back({2'b00, addr_of((k - 1) % 3), 11'b0});
                if (k == 1) begin
                    data = 12'($urandom_range(0, 4095));
                    sb_q.push_back('{l: mdl[0], m: mdl[1], r: mdl[2], v: 1'b0});
                end else begin
                    c = (k - 2) % 3;
                    data = use_fixed ? fixed_val[c] : 12'($urandom_range(0, 4095));
                    mdl[c] = data;
                    sb_q.push_back('{l: mdl[0], m: mdl[1], r: mdl[2], v: (c == 2)});
                end
                tx_word = {4'($urandom_range(0, 15)), data};
                fall_idx = 0;
            end
            if (!bus.adc_cs_n && m_prev_sck && !bus.adc_sck && fall_idx < 16) begin
                bus.adc_dout = tx_word[15 - fall_idx];
                fall_idx++;
            end
            m_prev_cs = bus.adc_cs_n;
            m_prev_sck = bus.adc_sck;
        end
    end

    int          cyc = 0;
    int          last_fall;
    int          last_tgl;
    int          last_valid;
    bit          have_fall;
    bit          have_valid;
    bit          is_latch;
    logic        p_cs;
    logic        p_sck;
    logic        p_dv;
    logic [15:0] din_cap;
    logic [15:0] exp_w;
    exp_t        e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            p_cs = 1'b1;
            p_sck = 1'b1;
            p_dv = 1'b0;
            have_fall = 1'b0;
            have_valid = 1'b0;
            rise_cnt = 0;
        end else begin
            is_latch = !p_cs && bus.adc_cs_n;
            if (p_cs && !bus.adc_cs_n) begin
                if (have_fall) chk("frame_period", cyc - last_fall, FramePeriod);
                last_fall = cyc;
                have_fall = 1'b1;
                last_tgl = cyc;
                rise_cnt = 0;
                din_cap = '0;
            end else if (!bus.adc_cs_n && bus.adc_sck != p_sck) begin
                chk("sck_half_period", cyc - last_tgl, ClkDiv);
                last_tgl = cyc;
                if (bus.adc_sck) begin
                    rise_cnt++;
                    din_cap = {din_cap[14:0], bus.adc_din};
                end
            end else if (is_latch) begin
                chk("sck_rises", rise_cnt, 16);
                chk("sck_tail", cyc - last_tgl, ClkDiv);
                if (din_q.size() == 0 || sb_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    exp_w = din_q.pop_front();
                    chk("din_word", din_cap, exp_w);
                    e = sb_q.pop_front();
                    chk("left", bus.left, e.l);
                    chk("middle", bus.middle, e.m);
                    chk("right", bus.right, e.r);
                    chk("data_valid", bus.data_valid, e.v);
                end
                last_din = din_cap;
                if (bus.data_valid) begin
                    if (have_valid) chk("valid_spacing", cyc - last_valid, 3 * FramePeriod);
                    last_valid = cyc;
                    have_valid = 1'b1;
                    valid_cnt++;
                end
                latch_cnt++;
            end
            if (bus.data_valid && !is_latch) chk("stray_valid", 1, 0);
            if (bus.data_valid && p_dv) chk("valid_width", 2, 1);
            p_cs = bus.adc_cs_n;
            p_sck = bus.adc_sck;
            p_dv = bus.data_valid;
        end
    end

    // Caller is positioned on the first negedge after reset release.
    task automatic check_gap();
        int n = 0;
        while (bus.adc_cs_n && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cs_gap_after_reset", n, GapCyc);
    endtask

    task automatic wait_latches(input int n);
        int target = latch_cnt + n;
        int budget = (n + 4) * FramePeriod;
        while (latch_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("latch_timeout", latch_cnt >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cs_n"}, bus.adc_cs_n, 1);
        chk({tag, "_sck"}, bus.adc_sck, 1);
        chk({tag, "_din"}, bus.adc_din, 0);
        chk({tag, "_left"}, bus.left, 0);
        chk({tag, "_middle"}, bus.middle, 0);
        chk({tag, "_right"}, bus.right, 0);
        chk({tag, "_valid"}, bus.data_valid, 0);
    endtask

    int v0;
    int budget;

    initial begin
        use_fixed = 1'b1;
        fixed_val[0] = 12'hABC;
        fixed_val[1] = 12'h123;
        fixed_val[2] = 12'hFFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_gap();

        v0 = valid_cnt;
        wait_latches(1);
        chk("first_frame_addr", last_din[13:11], 3'b011);
        wait_latches(2);
        chk("no_valid_before_frame4", valid_cnt - v0, 0);
        wait_latches(1);
        chk("valid_after_frame4", valid_cnt - v0, 1);
        chk("left_abc", bus.left, 12'hABC);
        chk("middle_123", bus.middle, 12'h123);
        chk("right_fff", bus.right, 12'hFFF);

        fixed_val[0] = 12'h000;
        wait_latches(3);
        chk("left_zero", bus.left, 12'h000);
        fixed_val[0] = 12'hFFF;
        wait_latches(3);
        chk("left_full", bus.left, 12'hFFF);

        use_fixed = 1'b0;
        budget = 3 * FramePeriod;
        @(negedge clk);
        while (!(!bus.adc_cs_n && rise_cnt == 7) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reached_sck7", rise_cnt, 7);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        check_gap();
        v0 = valid_cnt;
        wait_latches(3);
        chk("restart_no_valid", valid_cnt - v0, 0);
        wait_latches(1);
        chk("restart_valid", valid_cnt - v0, 1);

        v0 = valid_cnt;
        wait_latches(30);
        chk("valid_per_30_frames", valid_cnt - v0, 10);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
